store_data_buffer: RTL and testbench

STORE_DATA_BUFFER -- requirements
Module: store_data_buffer

---
 rtl/store_data_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_store_data_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_buffer.sv
// ---------------------------------------------------------------------------
// store_data_buffer
//
// Decouples CPU stores from a single-outstanding memory write port. Each
// accepted store is checked for natural alignment, formatted into a
// word-aligned address plus lane-replicated data and byte enables, and queued
// in a small FIFO. A two-state write engine (IDLE/BUSY) drains the FIFO one
// entry at a time. It holds Mem_Req and the write fields stable until Mem_Ack.
//
// Parameters
//   DEPTH     FIFO entries; legal values are 2 and 4.
//
// Ports
//   CLK       clock, all state updates on the rising edge
//   Reset     synchronous, active-high reset
//   St_Valid  store request valid
//   St_Ready  buffer can accept a store (FIFO occupancy < DEPTH)
//   St_Addr   store byte address
//   St_Data   store data, right-justified
//   St_Size   00 byte, 01 half, 10 word, 11 reserved (always rejected)
//   Mem_Req   memory write request (high while BUSY)
//   Mem_Ack   memory write accepted (ignored while IDLE)
//   Mem_Addr  word-aligned write address
//   Mem_Data  lane-aligned write data
//   Mem_BE    byte enables, bit i covers Mem_Data[8i+7:8i]
//   Misalign  one-cycle pulse the cycle after a rejected store
//   Empty     nothing queued and nothing in flight
//   Count     FIFO occupancy plus one while a write is in flight
// ---------------------------------------------------------------------------
module store_data_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        St_Valid,
  output logic        St_Ready,
  input  logic [31:0] St_Addr,
  input  logic [31:0] St_Data,
  input  logic [1:0]  St_Size,
  output logic        Mem_Req,
  input  logic        Mem_Ack,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Data,
  output logic [3:0]  Mem_BE,
  output logic        Misalign,
  output logic        Empty,
  output logic [2:0]  Count
);

  // Pointers wrap naturally because both legal depths are powers of two.
  localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A queue entry packs {addr[31:2], data[31:0], be[3:0]}. The two low
  // address bits are always zero, so they are not stored.
  localparam int ENTRY_W = 30 + 32 + 4;

  logic [ENTRY_W-1:0] entry_mem [DEPTH];

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [2:0]         occ_reg, occ_next;
  logic [31:0]        mem_addr_reg;
  logic [31:0]        mem_data_reg;
  logic [3:0]         mem_be_reg;
  logic               misalign_reg;

  logic               accept;
  logic               misaligned;
  logic               push;
  logic               pop;
  logic               mem_req_comb;
  logic [31:0]        fmt_data;
  logic [3:0]         fmt_be;
  logic [ENTRY_W-1:0] head;

  // -------------------------------------------------------------------------
  // Store acceptance and alignment
  // -------------------------------------------------------------------------
  assign St_Ready = (occ_reg < DEPTH_L);
  assign accept   = St_Valid & St_Ready;

  always_comb begin
    misaligned = 1'b0;
    case (St_Size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = St_Addr[0];
      SZ_WORD: misaligned = (St_Addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Rejected stores are consumed (handshake completes) but never queued.
  assign push = accept & ~misaligned;

  // -------------------------------------------------------------------------
  // Lane formatting. Each byte lane picks its source byte from the size:
  // bytes replicate St_Data[7:0], halves replicate St_Data[15:0], words pass
  // straight through. The enables select which replicated copy memory keeps.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign fmt_data[8*gi +: 8] =
          (St_Size == SZ_BYTE) ? St_Data[7:0] :
          (St_Size == SZ_HALF) ? St_Data[8*(gi%2) +: 8] :
                                 St_Data[8*gi +: 8];

      assign fmt_be[gi] =
          (St_Size == SZ_BYTE) ? (St_Addr[1:0] == 2'(gi)) :
          (St_Size == SZ_HALF) ? (St_Addr[1] == 1'(gi / 2)) :
                                 1'b1;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Entry storage. No reset is needed: the pointers and the occupancy decide
  // which entries are live. The head is captured into the write registers on
  // a pop, so the array only sees a registered read.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push) begin
      entry_mem[wr_ptr_reg] <= {St_Addr[31:2], fmt_data, fmt_be};
    end
  end

  assign head = entry_mem[rd_ptr_reg];

  // -------------------------------------------------------------------------
  // Write engine: next state and outputs.
  // The engine only looks at the registered occupancy. A store pushed in
  // this cycle therefore cannot be popped until the next one, which gives
  // the two-cycle store-to-request latency and no bypass path.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pop          = 1'b0;
    mem_req_comb = 1'b0;
    case (state_reg)
      IDLE: begin
        if (occ_reg != 3'd0) begin
          pop        = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_req_comb = 1'b1;
        if (Mem_Ack) begin
          if (occ_reg != 3'd0) begin
            // Back-to-back: the next head replaces the acknowledged write.
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A push and a pop in the same cycle cancel out in the occupancy.
  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 3'd1;
      2'b01:   occ_next = occ_reg - 3'd1;
      default: occ_next = occ_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= 3'd0;
      mem_addr_reg <= 32'd0;
      mem_data_reg <= 32'd0;
      mem_be_reg   <= 4'd0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      occ_reg      <= occ_next;
      misalign_reg <= accept & misaligned;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        mem_addr_reg <= {head[ENTRY_W-1:36], 2'b00};
        mem_data_reg <= head[35:4];
        mem_be_reg   <= head[3:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Mem_Req  = mem_req_comb;
  assign Mem_Addr = mem_addr_reg;
  assign Mem_Data = mem_data_reg;
  assign Mem_BE   = mem_be_reg;
  assign Misalign = misalign_reg;
  assign Count    = occ_reg + {2'b00, (state_reg == BUSY)};
  assign Empty    = (Count == 3'd0);

endmodule

// File: tb/tb_store_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_data_buffer
//
// Bench for store_data_buffer (DEPTH = 4). The stimulus side pushes each
// expected memory write into a scoreboard queue when a store is accepted. A
// monitor on the falling edge keeps a queue/counter view of the buffer.
// Every cycle it compares the status outputs, and it compares the write
// fields against the scoreboard head while a request is outstanding.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_store_data_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        St_Valid;
  logic        St_Ready;
  logic [31:0] St_Addr;
  logic [31:0] St_Data;
  logic [1:0]  St_Size;
  logic        Mem_Req;
  logic        Mem_Ack;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Data;
  logic [3:0]  Mem_BE;
  logic        Misalign;
  logic        Empty;
  logic [2:0]  Count;

  store_data_buffer #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .St_Valid (St_Valid),
    .St_Ready (St_Ready),
    .St_Addr  (St_Addr),
    .St_Data  (St_Data),
    .St_Size  (St_Size),
    .Mem_Req  (Mem_Req),
    .Mem_Ack  (Mem_Ack),
    .Mem_Addr (Mem_Addr),
    .Mem_Data (Mem_Data),
    .Mem_BE   (Mem_BE),
    .Misalign (Misalign),
    .Empty    (Empty),
    .Count    (Count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  wr_done = 0;
  bit  mon_en  = 1'b0;

  // Abstract buffer state: number of queued entries, one in flight or not,
  // and whether a rejection pulse is due.
  int  n_fifo  = 0;
  bit  busy_m  = 1'b0;
  bit  misal_m = 1'b0;
  int  exp_cnt;
  bit  acc_m;

  function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'b00:   return 1'b1;
      2'b01:   return (a[0] == 1'b0);
      2'b10:   return (a[1:0] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic wr_t expect_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] s);
    wr_t w;
    w.addr = a & 32'hFFFF_FFFC;
    case (s)
      2'b00: begin
        w.data = {4{d[7:0]}};
        w.be   = 4'b0001 << a[1:0];
      end
      2'b01: begin
        w.data = {2{d[15:0]}};
        w.be   = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w.data = d;
        w.be   = 4'b1111;
      end
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents one store and holds it until accepted. Returns 1 ns after the
  // accepting edge with St_Valid dropped.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    n        = 0;
    St_Valid = 1'b1;
    St_Addr  = a;
    St_Data  = d;
    St_Size  = s;
    @(negedge CLK);
    while (!St_Ready && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (!St_Ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got St_Ready=0 for 100 cycles expected acceptance");
    end else begin
      if (is_aligned(a, s)) exp_q.push_back(expect_write(a, d, s));
      $display("STORE addr=%h data=%h size=%0d", a, d, s);
    end
    @(posedge CLK);
    #1;
    St_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n       = 0;
    Mem_Ack = 1'b1;
    while (!Empty && n < 100) begin
      n++;
      tick(1);
    end
    chk("drain_empty", Empty, 1);
    chk("drain_scoreboard", exp_q.size(), 0);
    Mem_Ack = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Monitor: status checks every cycle, write checks against the scoreboard
  // head while a request is outstanding, then advance the abstract state.
  // -------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (mon_en) begin
      exp_cnt = n_fifo + int'(busy_m);
      chk("mem_req",  Mem_Req,  busy_m);
      chk("count",    Count,    exp_cnt);
      chk("empty",    Empty,    exp_cnt == 0);
      chk("st_ready", St_Ready, n_fifo < DEPTH);
      chk("misalign", Misalign, misal_m);

      if (busy_m) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got 0 entries expected at least 1");
        end else begin
          chk("mem_addr", Mem_Addr, exp_q[0].addr);
          chk("mem_data", Mem_Data, exp_q[0].data);
          chk("mem_be",   Mem_BE,   exp_q[0].be);
          if (Mem_Ack) begin
            $display("WRITE addr=%h data=%h be=%b", Mem_Addr, Mem_Data, Mem_BE);
            void'(exp_q.pop_front());
            wr_done++;
          end
        end
      end

      if (Reset) begin
        n_fifo  = 0;
        busy_m  = 1'b0;
        misal_m = 1'b0;
        exp_q.delete();
      end else begin
        acc_m = St_Valid && (n_fifo < DEPTH);
        // Hand-off uses the occupancy before this cycle's store lands.
        if (!busy_m) begin
          if (n_fifo > 0) begin
            busy_m = 1'b1;
            n_fifo--;
          end
        end else if (Mem_Ack) begin
          if (n_fifo > 0) n_fifo--;
          else            busy_m = 1'b0;
        end
        misal_m = acc_m && !is_aligned(St_Addr, St_Size);
        if (acc_m && !misal_m) n_fifo++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    logic [31:0] a;
    logic [1:0]  s;

    Reset    = 1'b1;
    St_Valid = 1'b0;
    St_Addr  = '0;
    St_Data  = '0;
    St_Size  = '0;
    Mem_Ack  = 1'b0;
    tick(1);
    mon_en = 1'b1;
    chk("rst_mem_req",  Mem_Req,  0);
    chk("rst_count",    Count,    0);
    chk("rst_empty",    Empty,    1);
    chk("rst_st_ready", St_Ready, 1);
    chk("rst_mem_addr", Mem_Addr, 0);
    chk("rst_mem_data", Mem_Data, 0);
    chk("rst_mem_be",   Mem_BE,   0);
    chk("rst_misalign", Misalign, 0);
    tick(1);
    Reset = 1'b0;
    tick(1);

    // Byte store, two-cycle latency, held until acknowledged.
    send(32'h0000_1003, 32'h0000_00AB, 2'b00);
    chk("byte_cycle1_req", Mem_Req, 0);
    tick(1);
    chk("byte_cycle2_req",  Mem_Req,  1);
    chk("byte_cycle2_addr", Mem_Addr, 32'h0000_1000);
    chk("byte_cycle2_data", Mem_Data, 32'hABAB_ABAB);
    chk("byte_cycle2_be",   Mem_BE,   4'b1000);
    tick(3);
    chk("byte_hold_req",  Mem_Req,  1);
    chk("byte_hold_data", Mem_Data, 32'hABAB_ABAB);
    Mem_Ack = 1'b1;
    tick(1);
    Mem_Ack = 1'b0;
    chk("byte_done_req", Mem_Req, 0);
    tick(2);

    // Half store, then word store.
    send(32'h0000_2002, 32'h0000_1234, 2'b01);
    tick(1);
    chk("half_addr", Mem_Addr, 32'h0000_2000);
    chk("half_data", Mem_Data, 32'h1234_1234);
    chk("half_be",   Mem_BE,   4'b1100);
    Mem_Ack = 1'b1;
    send(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
    drain();

    // Misaligned and reserved-size stores are rejected.
    send(32'h0000_2001, 32'h0000_5555, 2'b01);
    chk("misal_half_pulse", Misalign, 1);
    chk("misal_half_count", Count,    0);
    send(32'h0000_3002, 32'h7777_7777, 2'b10);
    chk("misal_word_pulse", Misalign, 1);
    chk("misal_word_count", Count,    0);
    send(32'h0000_4000, 32'h1111_1111, 2'b11);
    chk("misal_rsvd_pulse", Misalign, 1);
    tick(1);
    chk("misal_end_pulse", Misalign, 0);
    chk("misal_end_req",   Mem_Req,  0);
    chk("misal_end_count", Count,    0);

    // Back-pressure with Mem_Ack held low, then back-to-back drain.
    for (int i = 0; i < 5; i++) send(32'h0000_5000 + 32'(4 * i), $urandom, 2'b10);
    chk("bp_st_ready", St_Ready, 0);
    chk("bp_count",    Count,    5);
    w0      = wr_done;
    Mem_Ack = 1'b1;
    tick(5);
    chk("bp_back_to_back", wr_done - w0, 5);
    send(32'h0000_5014, 32'h0BAD_CAFE, 2'b10);
    drain();

    // Push and acknowledge in the same cycle at Count = 3.
    for (int i = 0; i < 3; i++) send(32'h0000_7000 + 32'(2 * i), $urandom, 2'b01);
    chk("pushpop_before", Count, 3);
    Mem_Ack = 1'b1;
    send(32'h0000_7007, 32'h0000_00EE, 2'b00);
    chk("pushpop_after", Count, 3);
    drain();

    // Reset while busy with three entries queued.
    for (int i = 0; i < 4; i++) send(32'h0000_8000 + 32'(4 * i), $urandom, 2'b10);
    chk("prerst_count", Count, 4);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("midrst_mem_req",  Mem_Req,  0);
    chk("midrst_count",    Count,    0);
    chk("midrst_empty",    Empty,    1);
    chk("midrst_st_ready", St_Ready, 1);
    send(32'h0000_6001, 32'h0000_005A, 2'b00);
    tick(1);
    chk("postrst_addr", Mem_Addr, 32'h0000_6000);
    chk("postrst_data", Mem_Data, 32'h5A5A_5A5A);
    chk("postrst_be",   Mem_BE,   4'b0010);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      Mem_Ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        if (!St_Ready) Mem_Ack = 1'b1;
        a = $urandom;
        s = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
          if (s == 2'b01) a[0] = 1'b0;
          if (s == 2'b10) a[1:0] = 2'b00;
          if (s == 2'b11) s = 2'b10;
          if (s == 2'b10) a[1:0] = 2'b00;
        end
        send(a, $urandom, s);
      end else begin
        tick(1);
      end
    end
    drain();
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
